// File: rtl/relay_frame_arbiter.sv
// relay_frame_arbiter: round-robin owner of one shared relay-chain stage.
// Each grant buys exactly one frame: a start pulse, a work window held
// until the stage reports its last element (or the watchdog gives up),
// then an optional guard gap before the next channel is considered.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | no frame; requests scanned from the round-robin pointer
// S_ISSUE | grant held; start pulse and window are launched on exit
// S_RUN   | window open; waiting for stage_last or watchdog expiry
// S_GAP   | guard gap after a frame; requests are not sampled

module relay_frame_arbiter #(
    parameter int N_REQ   = 4,
    parameter int IDX_W   = 2,
    parameter int CNT_W   = 8,
    parameter int TIMEOUT = 200,
    parameter int GAP     = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clk_ena,
    input  logic [N_REQ-1:0] req,
    input  logic             stage_last,
    output logic             first,
    output logic             windows,
    output logic [N_REQ-1:0] gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic [N_REQ-1:0] ack,
    output logic             err,
    output logic             busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_RUN   = 2'd2,
        S_GAP   = 2'd3
    } state_t;

    state_t           state, state_nxt;
    logic [IDX_W-1:0] ptr, ptr_nxt;
    logic [CNT_W-1:0] wd_cnt, wd_cnt_nxt;
    logic [CNT_W-1:0] gap_cnt, gap_cnt_nxt;

    logic             first_nxt;
    logic             windows_nxt;
    logic [N_REQ-1:0] gnt_nxt;
    logic [IDX_W-1:0] gnt_idx_nxt;
    logic [N_REQ-1:0] ack_nxt;
    logic             err_nxt;
    logic             busy_nxt;

    logic             found;
    logic [IDX_W-1:0] pick;
    logic [IDX_W:0]   sum;
    logic [IDX_W-1:0] ptr_adv;

    // Both counters run downward to a terminal count of zero.
    localparam logic [CNT_W-1:0] WD_LOAD  = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD = (GAP > 0) ? CNT_W'(GAP - 1) : '0;

    // Round-robin scan: first requester at or above the pointer, wrapping modulo N_REQ.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        sum   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            sum = {1'b0, ptr} + (IDX_W + 1)'(i);
            if (sum >= (IDX_W + 1)'(N_REQ)) begin
                sum = sum - (IDX_W + 1)'(N_REQ);
            end
            if (!found && req[sum[IDX_W-1:0]]) begin
                found = 1'b1;
                pick  = sum[IDX_W-1:0];
            end
        end
    end

    // Pointer moves just past the channel that owned the finished frame.
    always_comb begin
        if (gnt_idx == IDX_W'(N_REQ - 1)) begin
            ptr_adv = '0;
        end else begin
            ptr_adv = gnt_idx + IDX_W'(1);
        end
    end

    // Next-state and next-output logic; every output is registered from these.
    always_comb begin
        state_nxt   = state;
        ptr_nxt     = ptr;
        wd_cnt_nxt  = wd_cnt;
        gap_cnt_nxt = gap_cnt;
        first_nxt   = 1'b0;
        windows_nxt = windows;
        gnt_nxt     = gnt;
        gnt_idx_nxt = gnt_idx;
        ack_nxt     = '0;
        err_nxt     = 1'b0;
        busy_nxt    = busy;

        case (state)
            S_IDLE: begin
                if (found) begin
                    gnt_nxt     = N_REQ'(1) << pick;
                    gnt_idx_nxt = pick;
                    busy_nxt    = 1'b1;
                    state_nxt   = S_ISSUE;
                end
            end
            S_ISSUE: begin
                // stage_last is deliberately not looked at here.
                first_nxt   = 1'b1;
                windows_nxt = 1'b1;
                wd_cnt_nxt  = WD_LOAD;
                state_nxt   = S_RUN;
            end
            S_RUN: begin
                if (stage_last || (wd_cnt == '0)) begin
                    // stage_last wins a tie with the watchdog.
                    ack_nxt     = stage_last ? gnt : '0;
                    err_nxt     = !stage_last;
                    windows_nxt = 1'b0;
                    gnt_nxt     = '0;
                    ptr_nxt     = ptr_adv;
                    if (GAP > 0) begin
                        gap_cnt_nxt = GAP_LOAD;
                        state_nxt   = S_GAP;
                    end else begin
                        busy_nxt  = 1'b0;
                        state_nxt = S_IDLE;
                    end
                end else begin
                    wd_cnt_nxt = wd_cnt - CNT_W'(1);
                end
            end
            S_GAP: begin
                if (gap_cnt == '0) begin
                    busy_nxt  = 1'b0;
                    state_nxt = S_IDLE;
                end else begin
                    gap_cnt_nxt = gap_cnt - CNT_W'(1);
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // State, counters and registered outputs; everything freezes while clk_ena is low.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= S_IDLE;
            ptr     <= '0;
            wd_cnt  <= '0;
            gap_cnt <= '0;
            first   <= 1'b0;
            windows <= 1'b0;
            gnt     <= '0;
            gnt_idx <= '0;
            ack     <= '0;
            err     <= 1'b0;
            busy    <= 1'b0;
        end else if (clk_ena) begin
            state   <= state_nxt;
            ptr     <= ptr_nxt;
            wd_cnt  <= wd_cnt_nxt;
            gap_cnt <= gap_cnt_nxt;
            first   <= first_nxt;
            windows <= windows_nxt;
            gnt     <= gnt_nxt;
            gnt_idx <= gnt_idx_nxt;
            ack     <= ack_nxt;
            err     <= err_nxt;
            busy    <= busy_nxt;
        end
    end

endmodule

// File: tb/tb_relay_frame_arbiter.sv
// Bench for relay_frame_arbiter: a stimulus process drives frames and pushes
// the expected grant and frame-end results; a monitor pops and compares them.
module tb_relay_frame_arbiter;

    localparam int N  = 4;
    localparam int IW = 2;
    localparam int CW = 8;
    localparam int TO = 200;
    localparam int GP = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          clk_ena = 1'b1;
    logic [N-1:0]  req;
    logic          stage_last;
    logic          first;
    logic          windows;
    logic [N-1:0]  gnt;
    logic [IW-1:0] gnt_idx;
    logic [N-1:0]  ack;
    logic          err;
    logic          busy;

    relay_frame_arbiter #(
        .N_REQ(N), .IDX_W(IW), .CNT_W(CW), .TIMEOUT(TO), .GAP(GP)
    ) dut (
        .clk(clk), .rst(rst), .clk_ena(clk_ena), .req(req),
        .stage_last(stage_last), .first(first), .windows(windows),
        .gnt(gnt), .gnt_idx(gnt_idx), .ack(ack), .err(err), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    bit last_en  = 1'b0;
    bit rand_ena = 1'b0;
    bit mon_en   = 1'b0;

    typedef struct {
        bit is_ack;
        int idx;
        int wlen;
    } end_t;

    int   exp_gnt[$];
    end_t exp_end[$];

    int ptr_m   = 0;
    int cur_idx = 0;

    always @(posedge clk) last_en = clk_ena;

    always @(negedge clk) clk_ena = rand_ena ? ($urandom_range(0, 99) < 60) : 1'b1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_bound(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: wait bound expired (t=%0t)", name, $time);
    endtask

    // Reference arbitration: first requester scanning upward from the pointer, with wrap.
    function automatic int pick_ref(input logic [N-1:0] r, input int p);
        for (int i = 0; i < N; i++) begin
            if (r[(p + i) % N]) return (p + i) % N;
        end
        return -1;
    endfunction

    // ---------------- monitor ----------------
    logic [13:0]  snap;
    bit           snap_ok = 1'b0;
    logic [N-1:0] prev_gnt = '0;
    bit           prev_first = 1'b0;
    int           since_gnt = 0;
    int           wcnt = 0;
    int           since_end = 0;
    bit           gap_track = 1'b0;

    always @(negedge clk) begin
        logic [13:0] cur;
        int          e;
        end_t        x;
        cur = {first, windows, gnt, gnt_idx, ack, err, busy};
        if (!mon_en) begin
            prev_gnt   = '0;
            prev_first = 1'b0;
            gap_track  = 1'b0;
            wcnt       = 0;
            since_gnt  = 0;
        end else if (!last_en) begin
            if (snap_ok) chk("hold_when_disabled", cur, snap);
        end else begin
            since_gnt++;
            if (gnt != '0 && prev_gnt == '0) begin
                if (exp_gnt.size() == 0) begin
                    chk("unexpected_grant", gnt, '0);
                end else begin
                    e = exp_gnt.pop_front();
                    chk("gnt", gnt, 64'(N'(1) << e));
                    chk("gnt_idx", gnt_idx, 64'(e));
                end
                chk("first_at_grant", first, 1'b0);
                since_gnt = 0;
                wcnt      = 0;
            end
            if (first) begin
                chk("first_latency", since_gnt, 1);
                chk("first_single", prev_first, 1'b0);
            end
            if (windows) wcnt++;
            chk("gnt_onehot0", $onehot0(gnt), 1'b1);
            chk("ack_err_excl", (ack != '0) && err, 1'b0);
            if (gap_track) begin
                since_end++;
                if (!busy) begin
                    chk("gap_len", since_end, GP);
                    gap_track = 1'b0;
                end
            end
            if (ack != '0 || err) begin
                if (exp_end.size() == 0) begin
                    chk("unexpected_end", {ack, err}, '0);
                end else begin
                    x = exp_end.pop_front();
                    chk("ack", ack, x.is_ack ? 64'(N'(1) << x.idx) : 64'(0));
                    chk("err", err, !x.is_ack);
                    chk("window_len", wcnt, x.wlen);
                end
                gap_track = 1'b1;
                since_end = 0;
            end
            prev_gnt   = gnt;
            prev_first = first;
        end
        snap    = cur;
        snap_ok = mon_en;
    end

    // ---------------- stimulus ----------------
    task automatic step();
        do @(negedge clk); while (!last_en);
    endtask

    task automatic set_req(input logic [N-1:0] r);
        int g;
        req = r;
        g = pick_ref(r, ptr_m);
        if (g >= 0) begin
            exp_gnt.push_back(g);
            cur_idx = g;
            ptr_m   = (g + 1) % N;
        end
    endtask

    // k: enabled cycles between the first pulse and stage_last; never: no stage_last.
    task automatic run_frame(input int k, input bit never, input bit issue_pulse, input bit drop);
        int   b;
        end_t x;
        b = 0;
        while (gnt == '0 && b < 40) begin
            step();
            b++;
        end
        if (gnt == '0) begin
            fail_bound("grant_wait");
            return;
        end
        x.idx    = cur_idx;
        x.is_ack = !never && (k <= TO - 1);
        x.wlen   = x.is_ack ? k + 1 : TO;
        exp_end.push_back(x);
        if (issue_pulse) stage_last = 1'b1;
        step();
        stage_last = 1'b0;
        if (drop) req[cur_idx] = 1'b0;
        if (!x.is_ack) begin
            b = 0;
            while (!err && b < TO + 10) begin
                step();
                b++;
            end
            if (!err) fail_bound("err_wait");
        end else begin
            repeat (k) step();
            stage_last = 1'b1;
            step();
            stage_last = 1'b0;
        end
    endtask

    function automatic logic [N-1:0] next_req(input logic [N-1:0] r, input int served);
        logic [N-1:0] n;
        n = r;
        n[served] = 1'(($urandom_range(0, 1)));
        n = n | N'($urandom_range(0, 15) & $urandom_range(0, 15));
        if (n == '0) n[$urandom_range(0, N - 1)] = 1'b1;
        return n;
    endfunction

    initial begin
        int b;
        int k;
        rst        = 1'b0;
        req        = '0;
        stage_last = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 1'b0);
        chk("rst_gnt", gnt, '0);
        chk("rst_windows", windows, 1'b0);
        chk("rst_gnt_idx", gnt_idx, '0);
        #2 rst = 1'b1;
        mon_en = 1'b1;
        @(negedge clk);

        // Round robin with all channels held.
        set_req(4'b1111);
        for (int f = 0; f < 5; f++) begin
            run_frame(14, 1'b0, 1'b0, 1'b0);
            set_req(4'b1111);
        end
        // Watchdog abort, then the tie between stage_last and the timeout.
        run_frame(0, 1'b1, 1'b0, 1'b0);
        set_req(4'b1111);
        run_frame(TO - 1, 1'b0, 1'b0, 1'b0);
        set_req(4'b1111);
        // stage_last during the issue cycle must not end the frame.
        run_frame(5, 1'b0, 1'b1, 1'b0);
        set_req(4'b0000);
        repeat (6) step();

        // Single channel.
        set_req(4'b0010);
        run_frame(14, 1'b0, 1'b0, 1'b0);
        set_req(4'b0000);
        repeat (6) step();

        // Randomized traffic with a stuttering clock enable.
        rand_ena = 1'b1;
        set_req(next_req(4'b0000, 0));
        for (int f = 0; f < 25; f++) begin
            if ($urandom_range(0, 9) == 0) k = $urandom_range(TO - 3, TO + 2);
            else k = $urandom_range(0, 30);
            run_frame(k, 1'b0, 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)));
            set_req(next_req(req, cur_idx));
        end
        run_frame($urandom_range(0, 10), 1'b0, 1'b0, 1'b0);
        set_req(4'b0000);
        rand_ena = 1'b0;
        b = 0;
        while (busy && b < 20) begin
            step();
            b++;
        end
        if (busy) fail_bound("idle_wait");

        // Asynchronous reset in the middle of a frame owned by channel 2.
        set_req(4'b0100);
        b = 0;
        while (gnt == '0 && b < 20) begin
            step();
            b++;
        end
        repeat (4) step();
        chk("pre_reset_gnt", gnt, 4'b0100);
        #2;
        mon_en = 1'b0;
        rst    = 1'b0;
        #1;
        chk("async_rst_outputs", {first, windows, gnt, gnt_idx, ack, err, busy}, '0);
        exp_gnt.delete();
        exp_end.delete();
        ptr_m      = 0;
        req        = '0;
        stage_last = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_held_outputs", {first, windows, gnt, gnt_idx, ack, err, busy}, '0);
        #2 rst = 1'b1;
        mon_en = 1'b1;
        @(negedge clk);
        set_req(4'b0001);
        run_frame(6, 1'b0, 1'b0, 1'b0);
        set_req(4'b0000);
        repeat (6) step();

        chk("grant_queue_drained", exp_gnt.size(), 0);
        chk("end_queue_drained", exp_end.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

endmodule
